// File: rtl/cic_agc_ctrl_if.sv
// Signal bundle between the CIC output/control path and the gain controller.
// The master side drives samples and load requests; the slave side is the AGC.
interface cic_agc_ctrl_if;
    logic        enable;
    logic        d_clk;
    logic [11:0] d_in;
    logic        gain_load;
    logic [7:0]  gain_load_val;
    logic [7:0]  gain_out;
    logic        gain_update;
    logic [11:0] peak_out;
    logic        clip_out;
    logic [1:0]  state_out;

    modport master (
        output enable, d_clk, d_in, gain_load, gain_load_val,
        input  gain_out, gain_update, peak_out, clip_out, state_out
    );

    modport slave (
        input  enable, d_clk, d_in, gain_load, gain_load_val,
        output gain_out, gain_update, peak_out, clip_out, state_out
    );
endinterface

// File: rtl/cic_agc_ctrl.sv
// Automatic gain controller for the CIC decimator: measures the windowed peak
// magnitude of CIC output samples and steps the CIC output shift up or down.
module cic_agc_ctrl #(
    parameter int WINDOW    = 256,
    parameter int SETTLE    = 8,
    parameter int HI_THRESH = 1536,
    parameter int LO_THRESH = 512,
    parameter int GAIN_MIN  = 0,
    parameter int GAIN_MAX  = 52,
    parameter int GAIN_INIT = 0
) (
    input logic           clk,
    input logic           rst_n,
    cic_agc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_DECIDE  = 2'd2,
        S_SETTLE  = 2'd3
    } state_t;

    localparam int CNT_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] L_WIN_LAST = CW'(WINDOW - 1);
    localparam logic [CW-1:0] L_SET_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] L_CNT_ONE  = CW'(1);
    localparam logic [7:0]    L_GMIN     = 8'(GAIN_MIN);
    localparam logic [7:0]    L_GMAX     = 8'(GAIN_MAX);
    localparam logic [7:0]    L_GINIT    = 8'(GAIN_INIT);
    localparam logic [11:0]   L_HI       = 12'(HI_THRESH);
    localparam logic [11:0]   L_LO       = 12'(LO_THRESH);

    state_t        r_state;
    logic          r_dclk_q;
    logic [CW-1:0] r_cnt;
    logic [11:0]   r_peak;
    logic          r_clip;
    logic [7:0]    r_gain;
    logic          r_gain_update;
    logic [11:0]   r_peak_out;
    logic          r_clip_out;

    logic          w_stb;
    logic [11:0]   w_mag;
    logic          w_full;
    logic [7:0]    w_load_val;

    // Two's-complement negation of -2048 yields 12'h800, read unsigned as 2048.
    assign w_stb      = bus.d_clk & ~r_dclk_q;
    assign w_mag      = bus.d_in[11] ? (~bus.d_in + 12'd1) : bus.d_in;
    assign w_full     = (bus.d_in == 12'h7FF) || (bus.d_in == 12'h800);
    assign w_load_val = (bus.gain_load_val < L_GMIN) ? L_GMIN :
                        (bus.gain_load_val > L_GMAX) ? L_GMAX : bus.gain_load_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_dclk_q      <= 1'b0;
            r_cnt         <= '0;
            r_peak        <= '0;
            r_clip        <= 1'b0;
            r_gain        <= L_GINIT;
            r_gain_update <= 1'b0;
            r_peak_out    <= '0;
            r_clip_out    <= 1'b0;
        end else begin
            r_dclk_q      <= bus.d_clk;
            r_gain_update <= 1'b0;
            // A manual load overrides everything, including a decision in flight.
            if (bus.gain_load) begin
                r_gain        <= w_load_val;
                r_gain_update <= (w_load_val != r_gain);
                r_state       <= bus.enable ? S_SETTLE : S_IDLE;
                r_cnt         <= '0;
                r_peak        <= '0;
                r_clip        <= 1'b0;
                if (r_state == S_DECIDE && bus.enable) begin
                    r_peak_out <= r_peak;
                    r_clip_out <= r_clip;
                end
            end else if (!bus.enable) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_MEASURE;
                        r_cnt   <= '0;
                        r_peak  <= '0;
                        r_clip  <= 1'b0;
                    end
                    S_MEASURE: begin
                        if (w_stb) begin
                            r_peak <= (w_mag > r_peak) ? w_mag : r_peak;
                            r_clip <= r_clip | w_full;
                            r_cnt  <= r_cnt + L_CNT_ONE;
                            if (r_cnt == L_WIN_LAST) begin
                                r_state <= S_DECIDE;
                            end
                        end
                    end
                    S_DECIDE: begin
                        r_peak_out <= r_peak;
                        r_clip_out <= r_clip;
                        r_cnt      <= '0;
                        r_peak     <= '0;
                        r_clip     <= 1'b0;
                        r_state    <= S_MEASURE;
                        if (r_clip || r_peak >= L_HI) begin
                            if (r_gain > L_GMIN) begin
                                r_gain        <= r_gain - 8'd1;
                                r_gain_update <= 1'b1;
                                r_state       <= S_SETTLE;
                            end
                        end else if (r_peak < L_LO) begin
                            if (r_gain < L_GMAX) begin
                                r_gain        <= r_gain + 8'd1;
                                r_gain_update <= 1'b1;
                                r_state       <= S_SETTLE;
                            end
                        end
                    end
                    S_SETTLE: begin
                        if (w_stb) begin
                            if (r_cnt == L_SET_LAST) begin
                                r_state <= S_MEASURE;
                                r_cnt   <= '0;
                                r_peak  <= '0;
                                r_clip  <= 1'b0;
                            end else begin
                                r_cnt <= r_cnt + L_CNT_ONE;
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.gain_out    = r_gain;
    assign bus.gain_update = r_gain_update;
    assign bus.peak_out    = r_peak_out;
    assign bus.clip_out    = r_clip_out;
    assign bus.state_out   = r_state;
endmodule

// File: doc/cic_agc_ctrl.md
Name: cic_agc_ctrl

Overview:
- Automatic gain controller for the CIC decimator; drives the CIC 8-bit Gain input (output shift select).
- Observes the CIC 12-bit output samples, qualified by the rising edge of the CIC d_clk strobe, and measures the peak magnitude over a window of output samples.
- Steps gain down on clipping or high level and up on low level, then waits a settle period for the comb pipeline to flush.
- Sits between the CIC output and downstream demodulation/audio logic; also accepts a manual gain load from the control path.

Parameters:
- WINDOW, 256, output samples per measurement window (>=2).
- SETTLE, 8, output samples ignored after any gain change (>=1).
- HI_THRESH, 1536, peak magnitude at or above which gain decrements.
- LO_THRESH, 512, peak magnitude below which gain increments.
- GAIN_MIN, 0, lowest gain_out value.
- GAIN_MAX, 52, highest gain_out value (CIC register width minus 12).
- GAIN_INIT, 0, gain_out after reset.

Ports:
- clk  in  1  system clock, same as CIC clk.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  AGC run enable (level).
- d_clk  in  1  CIC output strobe (level).
- d_in  in  12  CIC d_out, signed.
- gain_load  in  1  one-cycle manual gain load request.
- gain_load_val  in  8  manual gain value.
- gain_out  out  8  gain to CIC Gain input.
- gain_update  out  1  one-cycle pulse whenever gain_out changes.
- peak_out  out  12  peak magnitude of the last completed window, unsigned.
- clip_out  out  1  last completed window contained a full-scale sample.
- state_out  out  2  current state: IDLE=0, MEASURE=1, DECIDE=2, SETTLE=3.

Behaviour:
- Reset (async, rst_n=0) forces the following:
  - gain_out=GAIN_INIT; gain_update=0; peak_out=0; clip_out=0.
  - state=IDLE; internal peak, clip and sample counter = 0; d_clk history register = 0.
- Sample strobe: stb = d_clk & ~d_clk_q, where d_clk_q is d_clk registered one cycle. d_in is sampled in the stb cycle.
- Magnitude: |d_in| as a 12-bit unsigned value; -2048 maps to 2048. A full-scale sample is d_in=2047 or d_in=-2048.
- IDLE:
  - Holds gain_out.
  - enable=1 -> MEASURE next cycle, clearing peak, clip and counter.
- MEASURE, on each stb:
  - peak=max(peak,|d_in|); clip|=full-scale; counter++.
  - On the stb that makes counter reach WINDOW -> DECIDE.
- DECIDE (exactly one clk):
  - Copy peak to peak_out and clip to clip_out.
  - If clip or peak>=HI_THRESH: if gain_out>GAIN_MIN, decrement gain_out and go to SETTLE; otherwise go to MEASURE.
  - Else if peak<LO_THRESH: if gain_out<GAIN_MAX, increment gain_out and go to SETTLE; otherwise go to MEASURE.
  - Else go to MEASURE.
  - Any transition to MEASURE clears peak, clip and counter.
- SETTLE:
  - Counts stb events, ignoring the sample data.
  - After SETTLE strobes -> MEASURE (cleared).
- gain_update: asserted for the single cycle after the edge on which gain_out takes a new value. A load of the value already held produces no pulse.
- Manual load: gain_load=1 in any state loads clamp(gain_load_val, GAIN_MIN, GAIN_MAX).
  - Then: SETTLE (counter cleared) if enable=1, else IDLE.
  - Has priority over the DECIDE adjustment in the same cycle.
- enable=0 in MEASURE/DECIDE/SETTLE -> IDLE next cycle.
  - gain_out, peak_out and clip_out are held.
  - A window in progress is discarded.
- stb arriving in the DECIDE cycle is dropped; it is not counted in the next window.
- Gain moves by at most 1 per DECIDE. gain_out never leaves [GAIN_MIN, GAIN_MAX].
- Latency: the last window stb sets state=DECIDE on the next edge; gain_out changes on the following edge.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Bench parameters: WINDOW=4, SETTLE=2, HI_THRESH=1536, LO_THRESH=512, GAIN_MIN=0, GAIN_MAX=52, GAIN_INIT=10. d_clk is a square wave of period 16 clk.
- Low level: enable=1, d_in=100 for 4 strobes -> peak_out=100, gain_out 10->11 with one gain_update pulse. Next window starts only after 2 strobes.
- Clip: window containing d_in=-2048 (others 0) -> clip_out=1, peak_out=2048, gain_out decrements by 1.
- In-band: constant d_in=1000 -> gain_out unchanged, no gain_update, state cycles MEASURE->DECIDE->MEASURE.
- Limits: GAIN_INIT=52 with d_in=0 -> gain_out stays 52, state goes DECIDE->MEASURE, no pulse. Mirror case at 0 with d_in=2047 -> gain_out stays 0.
- Manual load:
  - gain_load_val=200 -> gain_out=52, state=SETTLE.
  - gain_load asserted in the same cycle as an increment decision -> loaded value wins.
  - With enable=0 -> state=IDLE.
- Reset/enable abort: rst_n low mid-MEASURE -> all outputs take reset values immediately. enable dropped mid-window -> IDLE, gain_out held, next run starts with a fresh window.
